// File: rtl/spi_arbiter_if.sv
// Client + engine side bundle of the SPI arbiter. Per-requester fields are packed
// [NUM_REQ-1:0][W-1:0], so slice i sits at bits [i*W +: W] of the flat vector.
interface spi_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0][7:0]       req_tx_byte;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            tx_ack;
  logic [NUM_REQ-1:0]            rx_valid;
  logic [7:0]                    rx_byte;
  logic                          eng_start;
  logic [7:0]                    eng_tx_byte;
  logic                          eng_done;
  logic [7:0]                    eng_rx_byte;
  logic                          SS;

  // master: the arbiter itself; slave: clients, shift engine and SPI pins
  modport master (
    input  req, req_len, req_tx_byte, eng_done, eng_rx_byte,
    output grant, tx_ack, rx_valid, rx_byte, eng_start, eng_tx_byte, SS
  );
  modport slave (
    output req, req_len, req_tx_byte, eng_done, eng_rx_byte,
    input  grant, tx_ack, rx_valid, rx_byte, eng_start, eng_tx_byte, SS
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one SPI shift engine among NUM_REQ
// clients. Owns SS, frames multi-byte transactions and routes rx bytes to the owner.
module spi_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  spi_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   remaining, rem_n;
  logic [PTR_W-1:0]   owner, owner_n, rr_ptr, rr_n, pick;
  logic [NUM_REQ-1:0] grant, grant_n, tx_ack, tx_ack_n, rx_valid, rx_valid_n;
  logic [7:0]         rx_byte, rx_byte_n, eng_tx_byte, eng_tx_n;
  logic               eng_start, eng_start_n, ss, ss_n, go_start, found;
  int                 idx;

  // first set request at or after rr_ptr, cyclically
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rem_n       = remaining;
    owner_n     = owner;
    rr_n        = rr_ptr;
    grant_n     = grant;
    ss_n        = ss;
    rx_byte_n   = rx_byte;
    eng_tx_n    = eng_tx_byte;
    tx_ack_n    = '0;
    rx_valid_n  = '0;
    eng_start_n = 1'b0;
    go_start    = 1'b0;
    case (state)
      IDLE: if (found) begin
        owner_n        = pick;
        rem_n          = (bus.req_len[pick] == '0) ? LEN_W'(1) : bus.req_len[pick];
        grant_n        = '0;
        grant_n[pick]  = 1'b1;
        ss_n           = 1'b0;
        cnt_n          = '0;
        if (CS_SETUP > 0) state_n = SETUP;
        else              go_start = 1'b1;
      end
      SETUP: if (cnt == CNT_W'(CS_SETUP - 1)) go_start = 1'b1;
             else cnt_n = cnt + 1'b1;
      START: state_n = WAIT;
      WAIT: if (bus.eng_done) begin
        rx_byte_n         = bus.eng_rx_byte;
        rx_valid_n[owner] = 1'b1;
        if (remaining != '0) go_start = 1'b1;
        else begin
          ss_n    = 1'b1;
          grant_n = '0;
          rr_n    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          cnt_n   = '0;
          // the IDLE cycle that re-arbitrates is the last SS-high cycle of the gap
          state_n = (CS_HOLD > 1) ? HOLD : IDLE;
        end
      end
      HOLD: if (cnt == CNT_W'(CS_HOLD - 2)) state_n = IDLE;
            else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // every byte launch registers start, ack and data together so they share one cycle
    if (go_start) begin
      state_n           = START;
      eng_start_n       = 1'b1;
      eng_tx_n          = bus.req_tx_byte[owner_n];
      tx_ack_n[owner_n] = 1'b1;
      rem_n             = rem_n - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      remaining   <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      tx_ack      <= '0;
      rx_valid    <= '0;
      rx_byte     <= '0;
      eng_start   <= 1'b0;
      eng_tx_byte <= '0;
      ss          <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      remaining   <= rem_n;
      owner       <= owner_n;
      rr_ptr      <= rr_n;
      grant       <= grant_n;
      tx_ack      <= tx_ack_n;
      rx_valid    <= rx_valid_n;
      rx_byte     <= rx_byte_n;
      eng_start   <= eng_start_n;
      eng_tx_byte <= eng_tx_n;
      ss          <= ss_n;
    end
  end

  assign bus.grant       = grant;
  assign bus.tx_ack      = tx_ack;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_byte     = rx_byte;
  assign bus.eng_start   = eng_start;
  assign bus.eng_tx_byte = eng_tx_byte;
  assign bus.SS          = ss;
endmodule
